// File: rtl/axi_lite_slave_pkg.sv
// axi_lite_slave_pkg
// Shared constants and types for the AXI4-Lite register slave:
//   - word offsets of the four registers (address bits [3:2])
//   - response code, ID word value, data/strobe widths
//   - state encodings for the write and read handshake FSMs
// The ID register is enabled by defining AXIL_SLAVE_ID_REG_EN.
package axi_lite_slave_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_SCRATCH = 2'd2;
  localparam logic [1:0] ADDR_ID      = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [31:0] ID_VALUE = 32'h0005_0001;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCEPT = 2'd1,
    RD_DATA   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
// Register storage for the AXI4-Lite slave: CONTROL and SCRATCH storage with
// per-byte strobe merging, plus the combinational read mux.
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   wr_en          commit a write this edge (AW/W handshake)
//   wr_idx         word index of the write (address bits [3:2])
//   wr_data/strb   write data and byte enables
//   rd_idx         word index of the read
//   rd_data        combinational read value (pre-update, so a same-edge
//                  write is not visible to the read)
//   control        live CONTROL register value
//   status         user status input, returned at the STATUS offset
// Macro: AXIL_SLAVE_ID_REG_EN makes the ID offset return ID_VALUE (else 0).
module axi_lite_slave_regs
  import axi_lite_slave_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [1:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [1:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] control,
  input  logic [DATA_W-1:0] status
);

  logic [DATA_W-1:0] control_reg, control_next;
  logic [DATA_W-1:0] scratch_reg, scratch_next;

  logic control_sel;
  logic scratch_sel;

  assign control_sel = wr_en && (wr_idx == ADDR_CONTROL);
  assign scratch_sel = wr_en && (wr_idx == ADDR_SCRATCH);

  // Byte lanes with a clear strobe keep their previous contents.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_byte
      assign control_next[gi*8 +: 8] = (control_sel && wr_strb[gi]) ?
                                       wr_data[gi*8 +: 8] : control_reg[gi*8 +: 8];
      assign scratch_next[gi*8 +: 8] = (scratch_sel && wr_strb[gi]) ?
                                       wr_data[gi*8 +: 8] : scratch_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      control_reg <= '0;
      scratch_reg <= '0;
    end else begin
      control_reg <= control_next;
      scratch_reg <= scratch_next;
    end
  end

  assign control = control_reg;

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      ADDR_CONTROL: rd_data = control_reg;
      ADDR_STATUS:  rd_data = status;
      ADDR_SCRATCH: rd_data = scratch_reg;
      ADDR_ID: begin
`ifdef AXIL_SLAVE_ID_REG_EN
        rd_data = ID_VALUE;
`else
        rd_data = '0;
`endif
      end
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/axi_lite_slave.sv
// axi_lite_slave
// AXI4-Lite slave with a four-word register file (CONTROL, STATUS, SCRATCH, ID).
// Holds the independent write and read handshake FSMs; storage lives in
// axi_lite_slave_regs.
// Ports:
//   s_axi_aclk / s_axi_areset   clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w*        write address/data channels
//   s_axi_b*                    write response channel (always OKAY)
//   s_axi_ar* / s_axi_r*        read address/data channels (always OKAY)
//   control_reg_o               live copy of CONTROL
//   status_reg_i                user status, read at offset 0x4
// Macro: AXIL_SLAVE_ID_REG_EN enables the constant ID word at offset 0xC.
module axi_lite_slave
  import axi_lite_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   control_reg_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_reg_i
);

  wr_state_t wr_state_reg;
  rd_state_t rd_state_reg;

  logic              awready_reg;
  logic              wready_reg;
  logic              bvalid_reg;
  logic              arready_reg;
  logic              rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_data;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Handshakes complete on the edge where the registered ready pulse meets valid.
  assign wr_fire = awready_reg && wready_reg && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = arready_reg && s_axi_arvalid;

  // Write path: AW and W must be presented together.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_reg <= WR_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else begin
      case (wr_state_reg)
        WR_IDLE: begin
          if (s_axi_awvalid && s_axi_wvalid) begin
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
            wr_state_reg <= WR_ACCEPT;
          end
        end
        WR_ACCEPT: begin
          awready_reg <= 1'b0;
          wready_reg  <= 1'b0;
          // A master that withdrew its request gets no response.
          if (wr_fire) begin
            bvalid_reg   <= 1'b1;
            wr_state_reg <= WR_RESP;
          end else begin
            wr_state_reg <= WR_IDLE;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_reg   <= 1'b0;
            wr_state_reg <= WR_IDLE;
          end
        end
        default: begin
          awready_reg  <= 1'b0;
          wready_reg   <= 1'b0;
          bvalid_reg   <= 1'b0;
          wr_state_reg <= WR_IDLE;
        end
      endcase
    end
  end

  // Read path: rdata is captured at the AR handshake edge and held until rready.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_state_reg <= RD_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if (s_axi_arvalid) begin
            arready_reg  <= 1'b1;
            rd_state_reg <= RD_ACCEPT;
          end
        end
        RD_ACCEPT: begin
          arready_reg <= 1'b0;
          if (rd_fire) begin
            rdata_reg    <= rd_data;
            rvalid_reg   <= 1'b1;
            rd_state_reg <= RD_DATA;
          end else begin
            rd_state_reg <= RD_IDLE;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            rvalid_reg   <= 1'b0;
            rd_state_reg <= RD_IDLE;
          end
        end
        default: begin
          arready_reg  <= 1'b0;
          rvalid_reg   <= 1'b0;
          rd_state_reg <= RD_IDLE;
        end
      endcase
    end
  end

  axi_lite_slave_regs u_regs (
    .clk     (s_axi_aclk),
    .srst    (s_axi_areset),
    .wr_en   (wr_fire),
    .wr_idx  (s_axi_awaddr[3:2]),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_idx  (s_axi_araddr[3:2]),
    .rd_data (rd_data),
    .control (control_reg_o),
    .status  (status_reg_i)
  );

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_slave.sv
// tb_axi_lite_slave
// Self-checking bench for axi_lite_slave: directed register-map scenarios,
// back-pressure, same-edge read/write, mid-transaction reset and a random
// transaction mix, all compared against a word-level register model.
// Honours AXIL_SLAVE_ID_REG_EN for the expected ID word.
`timescale 1ns/1ps
module tb_axi_lite_slave;

  logic        clk;
  logic        areset;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] control_out;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  // Reference model: plain storage per register word.
  logic [31:0] m_control;
  logic [31:0] m_scratch;
`ifdef AXIL_SLAVE_ID_REG_EN
  localparam logic [31:0] ID_EXP = 32'h0005_0001;
`else
  localparam logic [31:0] ID_EXP = 32'h0000_0000;
`endif

  axi_lite_slave dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .control_reg_o (control_out),
    .status_reg_i  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_control;
      2'd1:    return status;
      2'd2:    return m_scratch;
      default: return ID_EXP;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = (a[3:2] == 2'd0) ? m_control : m_scratch;
    for (int b = 0; b < 4; b++)
      if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    if (a[3:2] == 2'd0) m_control = v;
    else if (a[3:2] == 2'd2) m_scratch = v;
  endtask

  // One complete write; bdelay cycles of bready low, during which a second
  // write request is held up to prove it is not accepted.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdelay);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(awready && wready) && n < 20);
    if (!(awready && wready)) begin
      check_eq("wr_accept_timeout", 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    check_eq("wr_ready_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s);
    check_eq("wr_bvalid", 32'(bvalid), 32'd1);
    check_eq("wr_bresp", 32'(bresp), 32'd0);
    check_eq("wr_awready_drop", 32'(awready), 32'd0);
    check_eq("wr_control_out", control_out, m_control);
    for (int i = 0; i < bdelay; i++) begin
      awaddr = 4'h0; wdata = ~d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      check_eq("wr_bvalid_hold", 32'(bvalid), 32'd1);
      check_eq("wr_no_second_accept", 32'({awready, wready}), 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_eq("wr_bvalid_clear", 32'(bvalid), 32'd0);
    check_eq("wr_control_after", control_out, m_control);
    $display("WR addr=%h data=%h strb=%h bdelay=%0d", a, d, s, bdelay);
  endtask

  // One complete read; expectation is fixed at entry (before any overlapping write).
  task automatic axi_read(input logic [3:0] a, input int rdelay);
    int n;
    logic [31:0] exp;
    exp = model_read(a);
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!arready && n < 20);
    if (!arready) begin
      check_eq("rd_accept_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
      return;
    end
    check_eq("rd_ready_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_eq("rd_rvalid", 32'(rvalid), 32'd1);
    check_eq("rd_rresp", 32'(rresp), 32'd0);
    check_eq("rd_data", rdata, exp);
    for (int i = 0; i < rdelay; i++) begin
      araddr = a ^ 4'h4; arvalid = 1'b1;
      @(posedge clk); #1;
      check_eq("rd_rvalid_hold", 32'(rvalid), 32'd1);
      check_eq("rd_data_hold", rdata, exp);
      check_eq("rd_no_second_accept", 32'(arready), 32'd0);
    end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_eq("rd_rvalid_clear", 32'(rvalid), 32'd0);
    $display("RD addr=%h data=%h exp=%h rdelay=%0d", a, rdata, exp, rdelay);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_hs"}, 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
    check_eq({tag, "_resp"}, 32'({bresp, rresp}), 32'd0);
    check_eq({tag, "_rdata"}, rdata, 32'd0);
    check_eq({tag, "_control"}, control_out, 32'd0);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status = '0; m_control = '0; m_scratch = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    check_idle_outputs("reset");

    // Register map walk-through.
    axi_write(4'h0, 32'h1234_5678, 4'hF, 0);
    check_eq("control_direct", control_out, 32'h1234_5678);
    axi_read(4'h0, 0);
    status = 32'hDEAD_BEEF;
    axi_read(4'h4, 0);
    axi_write(4'h8, 32'hAA55_AA55, 4'hF, 0);
    axi_read(4'h8, 0);
    axi_write(4'h8, 32'h0000_FFFF, 4'h3, 0);
    axi_read(4'h8, 0);
    check_eq("scratch_strobe", m_scratch, 32'hAA55_FFFF);
    axi_write(4'h4, 32'h0BAD_C0DE, 4'hF, 0);
    status = 32'h00C0_FFEE;
    axi_read(4'h4, 0);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0);
    axi_read(4'hC, 0);
    axi_read(4'h3, 0);

    // Back-pressure on both response channels.
    axi_write(4'h0, 32'hCAFE_0001, 4'hF, 5);
    axi_read(4'h0, 5);

    // Read and write to the same offset on the same edge: read sees old value.
    fork
      axi_write(4'h8, 32'h5555_6666, 4'hF, 1);
      axi_read(4'h8, 2);
    join
    axi_read(4'h8, 0);

    // Reset while a write response is pending.
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_eq("midrst_bvalid_pending", 32'(bvalid), 32'd1);
    check_eq("midrst_control_written", control_out, 32'hCAFE_F00D);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    m_control = '0; m_scratch = '0;
    check_idle_outputs("midrst");
    $display("RST mid-write");
    axi_read(4'h8, 0);
    axi_write(4'h0, 32'h0F0F_1234, 4'hF, 0);
    axi_read(4'h0, 0);

    // Random mix.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        1: begin
          status = $urandom;
          axi_read(a, $urandom_range(0, 3));
        end
        default: begin
          status = $urandom;
          fork
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
          join
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
